mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single SRAM-like memory port between instruction fetch (IF) and the data access (MEM stage).
- Sequences each transfer through an address phase and a data phase, and returns read data plus a one-cycle completion pulse to the owner.
- Raises per-requester stall requests that feed the pipeline control block's stall bus.
- Lets the 5-stage pipeline keep a single memory interface while IF and MEM contend for it.

Parameters:
- ADDR_W, 32, address width of requester and memory ports
- DATA_W, 32, data width; must be a multiple of 8 (write strobe width is DATA_W/8)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); released synchronously upstream
- inst_req  in  1  IF read request; held high until inst_ok
- inst_addr  in  ADDR_W  IF fetch address; stable while inst_req is high
- inst_rdata  out  DATA_W  fetched word; valid while inst_ok is high
- inst_ok  out  1  one-cycle completion pulse for IF
- data_req  in  1  MEM request; held high until data_ok
- data_wen  in  DATA_W/8  byte write enables; 0 means read
- data_addr  in  ADDR_W  MEM address
- data_wdata  in  DATA_W  MEM store data
- data_rdata  out  DATA_W  load data; valid while data_ok is high
- data_ok  out  1  one-cycle completion pulse for MEM
- mem_req  out  1  memory request valid
- mem_wr  out  1  1 = write
- mem_wstrb  out  DATA_W/8  byte strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_addr_ok  in  1  memory accepted the address phase
- mem_data_ok  in  1  memory completed the data phase
- mem_rdata  in  DATA_W  memory read data; valid with mem_data_ok
- stallreq_for_inst  out  1  IF must stall
- stallreq_for_data  out  1  MEM must stall

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE; owner=NONE; last_grant=INST
  - mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0
  - inst_ok=0, data_ok=0, inst_rdata=0, data_rdata=0
- Reset mid-transfer abandons the transfer; no ok pulse is ever issued for it. The memory is reset by the same rst.
- All mem_* outputs, *_ok and *_rdata are registered.
- The stall outputs are combinational:
  - stallreq_for_inst = inst_req & ~inst_ok
  - stallreq_for_data = data_req & ~data_ok
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Eligible requester = req high and its ok not high this cycle. This prevents re-granting a request in its completion cycle.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: latch addr, wen, wdata into mem_*; mem_wr = |wen; mem_req=1; set owner and last_grant; go to ADDR.
- ADDR:
  - Hold mem_req and all mem_* stable until mem_addr_ok=1.
  - On mem_addr_ok: mem_req=0 next cycle.
  - If mem_data_ok is also high in the same cycle, complete (see Completion). Otherwise go to DATA.
- DATA:
  - mem_req=0; wait for mem_data_ok.
  - On mem_data_ok: complete.
- Completion:
  - Next cycle: owner's ok=1 for exactly one cycle; owner's rdata = mem_rdata (writes also update rdata; the value is don't-care).
  - state=IDLE, owner=NONE.
  - The non-owner's rdata holds its previous value.
- Spurious inputs:
  - mem_data_ok in IDLE or ADDR without mem_addr_ok is ignored.
  - mem_addr_ok outside ADDR is ignored.
- Minimum latency for a transfer whose memory responds with mem_addr_ok on the first mem_req cycle and mem_data_ok one cycle later:
  - req sampled in IDLE at cycle 0
  - mem_req high at cycle 1, with mem_addr_ok at cycle 1
  - mem_data_ok at cycle 2
  - ok at cycle 3
- Back-to-back: the ok cycle is an IDLE cycle, so a pending other requester is granted in that same cycle, with mem_req at ok+1.
- Dropping req before ok is illegal (checked by assertion); the arbiter still completes the transfer and pulses ok.

Decomposition:
- Shared package/defines:
  - StallBus width (6)
  - FSM state encodings: IDLE, ADDR, DATA
  - owner encoding: NONE, INST, DATA
- No sub-module needed. Optional: factor a 2-way round-robin grant picker, rr_pick2, if reused by a later cache arbiter.

Test Plan:
- Single IF read, addr 0x0000_0040, memory returns addr_ok at cycle 1 and data_ok at cycle 2 with 0x2402_0005 -> inst_ok=1 at cycle 3 only, inst_rdata=0x2402_0005; stallreq_for_inst high cycles 0-2, low at 3.
- Single data store, addr 0x1000_0004, wen=4'b0011, wdata=0xAABB_CCDD -> mem_wr=1, mem_wstrb=4'b0011, mem_wdata=0xAABB_CCDD; data_ok one pulse; inst_* untouched.
- inst_req and data_req both raised in the same cycle after reset (last_grant=INST) -> data granted first. Then inst is granted in data_ok's cycle, mem_req at the next cycle. Both ok pulses occur exactly once, in order DATA, INST.
- Memory delays mem_addr_ok by 3 cycles -> mem_req and mem_addr stay stable for all 4 cycles. mem_addr_ok and mem_data_ok arriving in the same cycle -> DATA state is skipped and ok follows next cycle.
- Requester keeps req high through its ok cycle with nothing else pending -> no second grant; mem_req stays 0 the cycle after ok.
- rst driven low while in DATA -> all outputs are 0 immediately (asynchronous), no ok pulse after release, and the next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, owner encoding
// and the two-way round-robin grant picker.
package mem_port_arbiter_pkg;

  localparam int unsigned STALL_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  // A sole eligible requester wins; on contention the one not granted last wins.
  function automatic owner_e rr_pick2(input logic i_inst, input logic i_data,
                                      input owner_e i_last);
    if (i_inst && (!i_data || i_last == OWN_DATA)) return OWN_INST;
    else if (i_data) return OWN_DATA;
    else return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view,
// master = the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_ok;
  logic              data_req;
  logic [STRB_W-1:0] data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ok;
  logic              mem_req;
  logic              mem_wr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;
  logic              stallreq_for_inst;
  logic              stallreq_for_data;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
           mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_rdata, inst_ok, data_rdata, data_ok,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
           stallreq_for_inst, stallreq_for_data
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
           mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_rdata, inst_ok, data_rdata, data_ok,
           mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
           stallreq_for_inst, stallreq_for_data
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and the MEM stage,
// sequencing address and data phases and pulsing a one-cycle ok to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e            r_state,      w_state_nxt;
  owner_e            r_owner,      w_owner_nxt;
  owner_e            r_last,       w_last_nxt;
  owner_e            w_pick;
  logic              r_mem_req,    w_mem_req_nxt;
  logic              r_mem_wr,     w_mem_wr_nxt;
  logic [STRB_W-1:0] r_mem_wstrb,  w_mem_wstrb_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic              r_inst_ok,    w_inst_ok_nxt;
  logic              r_data_ok,    w_data_ok_nxt;
  logic [DATA_W-1:0] r_inst_rdata, w_inst_rdata_nxt;
  logic [DATA_W-1:0] r_data_rdata, w_data_rdata_nxt;
  logic              w_done;
  logic              w_inst_elig;
  logic              w_data_elig;

  // A request in its own completion cycle is not eligible, so it is never re-granted.
  assign w_inst_elig = bus.inst_req & ~r_inst_ok;
  assign w_data_elig = bus.data_req & ~r_data_ok;
  assign w_pick      = rr_pick2(w_inst_elig, w_data_elig, r_last);

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_nxt       = r_last;
    w_mem_req_nxt    = r_mem_req;
    w_mem_wr_nxt     = r_mem_wr;
    w_mem_wstrb_nxt  = r_mem_wstrb;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_inst_ok_nxt    = 1'b0;
    w_data_ok_nxt    = 1'b0;
    w_inst_rdata_nxt = r_inst_rdata;
    w_data_rdata_nxt = r_data_rdata;
    w_done           = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_pick == OWN_INST) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_wr_nxt    = 1'b0;
          w_mem_wstrb_nxt = '0;
          w_mem_addr_nxt  = bus.inst_addr;
          w_mem_wdata_nxt = '0;
          w_owner_nxt     = OWN_INST;
          w_last_nxt      = OWN_INST;
          w_state_nxt     = S_ADDR;
        end else if (w_pick == OWN_DATA) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_wr_nxt    = |bus.data_wen;
          w_mem_wstrb_nxt = bus.data_wen;
          w_mem_addr_nxt  = bus.data_addr;
          w_mem_wdata_nxt = bus.data_wdata;
          w_owner_nxt     = OWN_DATA;
          w_last_nxt      = OWN_DATA;
          w_state_nxt     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.mem_addr_ok) begin
          w_mem_req_nxt = 1'b0;
          if (bus.mem_data_ok) w_done = 1'b1;
          else w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.mem_data_ok) w_done = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Completion: route read data and the ok pulse to the owner only.
    if (w_done) begin
      w_state_nxt = S_IDLE;
      w_owner_nxt = OWN_NONE;
      if (r_owner == OWN_INST) begin
        w_inst_ok_nxt    = 1'b1;
        w_inst_rdata_nxt = bus.mem_rdata;
      end else if (r_owner == OWN_DATA) begin
        w_data_ok_nxt    = 1'b1;
        w_data_rdata_nxt = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_last       <= OWN_INST;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last       <= w_last_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_inst_ok    <= w_inst_ok_nxt;
      r_data_ok    <= w_data_ok_nxt;
      r_inst_rdata <= w_inst_rdata_nxt;
      r_data_rdata <= w_data_rdata_nxt;
    end
  end

  assign bus.mem_req           = r_mem_req;
  assign bus.mem_wr            = r_mem_wr;
  assign bus.mem_wstrb         = r_mem_wstrb;
  assign bus.mem_addr          = r_mem_addr;
  assign bus.mem_wdata         = r_mem_wdata;
  assign bus.inst_ok           = r_inst_ok;
  assign bus.data_ok           = r_data_ok;
  assign bus.inst_rdata        = r_inst_rdata;
  assign bus.data_rdata        = r_data_rdata;
  assign bus.stallreq_for_inst = bus.inst_req & ~r_inst_ok;
  assign bus.stallreq_for_data = bus.data_req & ~r_data_ok;

  // A requester must hold req for as long as it owns the port.
  a_inst_held: assert property (@(posedge clk) disable iff (!rst)
                                (r_owner == OWN_INST) |-> bus.inst_req);
  a_data_held: assert property (@(posedge clk) disable iff (!rst)
                                (r_owner == OWN_DATA) |-> bus.data_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: stimulus pushes expected
// completions, a monitor pops them on every ok pulse.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) io ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  int          total = 0;
  int          bad   = 0;
  int          n_ok  = 0;
  int unsigned cfg_addr_delay = 0;
  int unsigned cfg_data_delay = 1;
  bit          cfg_spurious   = 1'b0;
  logic [31:0] mem_model [logic [31:0]];
  exp_t        sb_q [$];
  exp_t        mon_e;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [3:0] s,
                                    input logic [31:0] d);
    logic [31:0] v;
    v = mem_model.exists(a) ? mem_model[a] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = v;
  endfunction

  // Memory responder: addr_ok after cfg_addr_delay cycles of mem_req,
  // data_ok cfg_data_delay cycles after addr_ok (0 = same cycle).
  initial begin
    int unsigned wait_cnt;
    int unsigned dwait;
    bit          pend;
    logic [31:0] rd_val;
    logic [31:0] hold_addr;
    wait_cnt = 0; dwait = 0; pend = 1'b0; rd_val = '0; hold_addr = '0;
    io.mem_addr_ok = 1'b0; io.mem_data_ok = 1'b0; io.mem_rdata = '0;
    forever begin
      @(negedge clk);
      io.mem_addr_ok = 1'b0;
      io.mem_data_ok = 1'b0;
      if (!rst) begin
        wait_cnt = 0;
        pend     = 1'b0;
      end else if (pend) begin
        if (dwait == 0) begin
          io.mem_data_ok = 1'b1;
          io.mem_rdata   = rd_val;
          pend           = 1'b0;
        end else dwait--;
      end else if (io.mem_req) begin
        if (wait_cnt == 0) hold_addr = io.mem_addr;
        else check("addr_stable", 64'(io.mem_addr), 64'(hold_addr));
        if (wait_cnt < cfg_addr_delay) begin
          wait_cnt++;
          if (cfg_spurious) begin
            io.mem_data_ok = 1'b1;
            io.mem_rdata   = 32'hDEAD_BEEF;
          end
        end else begin
          wait_cnt       = 0;
          io.mem_addr_ok = 1'b1;
          rd_val = mem_model.exists(io.mem_addr) ? mem_model[io.mem_addr] : 32'h0;
          if (io.mem_wr) mem_write(io.mem_addr, io.mem_wstrb, io.mem_wdata);
          if (cfg_data_delay == 0) begin
            io.mem_data_ok = 1'b1;
            io.mem_rdata   = rd_val;
          end else begin
            pend  = 1'b1;
            dwait = cfg_data_delay - 1;
          end
        end
      end else if (cfg_spurious) begin
        io.mem_addr_ok = 1'b1;
        io.mem_data_ok = 1'b1;
        io.mem_rdata   = 32'hBAD0_0BAD;
      end
    end
  end

  // Monitor: every ok pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (io.inst_ok === 1'b1 || io.data_ok === 1'b1)) begin
      n_ok++;
      if (sb_q.size() == 0) begin
        check("unexpected_ok", 64'(io.data_ok), 64'(io.inst_ok) + 64'd2);
      end else begin
        mon_e = sb_q.pop_front();
        check("ok_owner", 64'(io.data_ok), 64'(mon_e.is_data));
        if (mon_e.chk)
          check("ok_rdata", 64'(mon_e.is_data ? io.data_rdata : io.inst_rdata),
                64'(mon_e.rdata));
      end
    end
  end

  task automatic start_req(input bit is_data, input logic [31:0] addr,
                           input logic [3:0] wen, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit chk,
                           input bit expect_ok);
    exp_t e;
    if (expect_ok) begin
      e.is_data = is_data; e.chk = chk; e.rdata = exp_rd;
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (is_data) begin
      io.data_req = 1'b1; io.data_addr = addr; io.data_wen = wen; io.data_wdata = wdata;
    end else begin
      io.inst_req = 1'b1; io.inst_addr = addr;
    end
  endtask

  // Waits for the requester's ok, holds req through the ok cycle, then drops it.
  task automatic finish_req(input bit is_data, input int lat0, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = lat0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #1;
      lat++;
      if (is_data ? io.data_ok : io.inst_ok) seen = 1'b1;
    end
    if (!seen) check("ok_timeout", 64'd0, 64'd1);
    @(negedge clk); #1;
    if (!(is_data ? io.inst_req : io.data_req))
      check("no_regrant_memreq", 64'(io.mem_req), 64'd0);
    if (is_data) io.data_req = 1'b0;
    else io.inst_req = 1'b0;
  endtask

  task automatic run_req(input bit is_data, input logic [31:0] addr,
                         input logic [3:0] wen, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit chk, output int lat);
    start_req(is_data, addr, wen, wdata, exp_rd, chk, 1'b1);
    finish_req(is_data, 0, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    io.inst_req = 1'b0; io.data_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    int  ok_before;
    rst = 1'b0;
    io.inst_req = 1'b0; io.inst_addr = '0;
    io.data_req = 1'b0; io.data_wen = '0; io.data_addr = '0; io.data_wdata = '0;
    mem_model[32'h0000_0040] = 32'h2402_0005;
    mem_model[32'h0000_0044] = 32'h8C43_0008;
    mem_model[32'h0000_0048] = 32'h0001_0203;
    mem_model[32'h1000_0004] = 32'h1122_3344;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req",    64'(io.mem_req),    64'd0);
    check("rst_mem_wr",     64'(io.mem_wr),     64'd0);
    check("rst_mem_addr",   64'(io.mem_addr),   64'd0);
    check("rst_inst_ok",    64'(io.inst_ok),    64'd0);
    check("rst_data_rdata", 64'(io.data_rdata), 64'd0);
    check("rst_stall_inst", 64'(io.stallreq_for_inst), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single IF read with minimum latency, cycle by cycle.
    sb_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: 32'h2402_0005});
    @(negedge clk);
    io.inst_req = 1'b1; io.inst_addr = 32'h0000_0040;
    #1;
    check("t1_c0_stall",  64'(io.stallreq_for_inst), 64'd1);
    check("t1_c0_memreq", 64'(io.mem_req), 64'd0);
    @(negedge clk); #1;
    check("t1_c1_memreq", 64'(io.mem_req),  64'd1);
    check("t1_c1_addr",   64'(io.mem_addr), 64'h40);
    check("t1_c1_wr",     64'(io.mem_wr),   64'd0);
    check("t1_c1_stall",  64'(io.stallreq_for_inst), 64'd1);
    @(negedge clk); #1;
    check("t1_c2_memreq", 64'(io.mem_req), 64'd0);
    check("t1_c2_ok",     64'(io.inst_ok), 64'd0);
    check("t1_c2_stall",  64'(io.stallreq_for_inst), 64'd1);
    @(negedge clk); #1;
    check("t1_c3_ok",     64'(io.inst_ok),    64'd1);
    check("t1_c3_rdata",  64'(io.inst_rdata), 64'h2402_0005);
    check("t1_c3_stall",  64'(io.stallreq_for_inst), 64'd0);
    @(negedge clk); #1;
    check("t1_c4_ok",     64'(io.inst_ok), 64'd0);
    check("t1_c4_memreq", 64'(io.mem_req), 64'd0);
    io.inst_req = 1'b0;

    // Partial-word store; instruction side must be left alone.
    start_req(1'b1, 32'h1000_0004, 4'b0011, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("t2_wr",    64'(io.mem_wr),    64'd1);
    check("t2_wstrb", 64'(io.mem_wstrb), 64'h3);
    check("t2_wdata", 64'(io.mem_wdata), 64'hAABB_CCDD);
    check("t2_addr",  64'(io.mem_addr),  64'h1000_0004);
    finish_req(1'b1, 1, lat);
    check("t2_lat", 64'(lat), 64'd3);
    check("t2_inst_rdata_kept", 64'(io.inst_rdata), 64'h2402_0005);

    // Simultaneous requests right after reset: DATA first, INST back-to-back.
    do_reset();
    sb_q.push_back('{is_data: 1'b1, chk: 1'b1, rdata: 32'h1122_CCDD});
    sb_q.push_back('{is_data: 1'b0, chk: 1'b1, rdata: 32'h8C43_0008});
    @(negedge clk);
    io.data_req = 1'b1; io.data_addr = 32'h1000_0004; io.data_wen = 4'b0000;
    io.inst_req = 1'b1; io.inst_addr = 32'h0000_0044;
    @(negedge clk); #1;
    check("t3_first_addr", 64'(io.mem_addr), 64'h1000_0004);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (io.data_ok) seen = 1'b1;
    end
    check("t3_data_ok_seen", 64'(seen), 64'd1);
    check("t3_okcyc_memreq", 64'(io.mem_req), 64'd0);
    @(negedge clk); #1;
    check("t3_inst_memreq", 64'(io.mem_req),  64'd1);
    check("t3_inst_addr",   64'(io.mem_addr), 64'h44);
    io.data_req = 1'b0;
    finish_req(1'b0, 0, lat);
    check("t3_inst_lat", 64'(lat), 64'd2);

    // Slow address phase, merged addr/data ok, spurious handshakes around it.
    cfg_addr_delay = 3; cfg_data_delay = 0; cfg_spurious = 1'b1;
    repeat (3) @(negedge clk);
    run_req(1'b0, 32'h0000_0048, 4'b0, 32'h0, 32'h0001_0203, 1'b1, lat);
    check("t4_lat", 64'(lat), 64'd5);
    repeat (2) @(negedge clk);
    cfg_addr_delay = 0; cfg_data_delay = 1; cfg_spurious = 1'b0;

    // Plain reads/writes with req held through ok.
    run_req(1'b0, 32'h0000_0040, 4'b0, 32'h0, 32'h2402_0005, 1'b1, lat);
    check("t5_inst_lat", 64'(lat), 64'd3);
    run_req(1'b1, 32'h1000_0008, 4'b1100, 32'h5566_7788, 32'h0, 1'b0, lat);
    run_req(1'b1, 32'h1000_0008, 4'b0000, 32'h0, 32'h5566_0000, 1'b1, lat);
    check("t5_data_lat", 64'(lat), 64'd3);

    // Reset while in DATA: transfer abandoned, then normal service.
    cfg_data_delay = 3;
    start_req(1'b0, 32'h0000_0044, 4'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_mem_req",    64'(io.mem_req),    64'd0);
    check("t6_mem_addr",   64'(io.mem_addr),   64'd0);
    check("t6_mem_wdata",  64'(io.mem_wdata),  64'd0);
    check("t6_mem_wstrb",  64'(io.mem_wstrb),  64'd0);
    check("t6_inst_rdata", 64'(io.inst_rdata), 64'd0);
    check("t6_data_rdata", 64'(io.data_rdata), 64'd0);
    check("t6_ok",         64'({io.inst_ok, io.data_ok}), 64'd0);
    io.inst_req = 1'b0;
    ok_before = n_ok;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cfg_data_delay = 1;
    repeat (6) @(negedge clk);
    check("t6_no_ok_after_rst", 64'(n_ok), 64'(ok_before));
    run_req(1'b0, 32'h0000_0040, 4'b0, 32'h0, 32'h2402_0005, 1'b1, lat);
    check("t6_lat", 64'(lat), 64'd3);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
